// File: rtl/md_iter_unit.sv
// -----------------------------------------------------------------------------
// md_iter_unit
//
// Iterative multiply/divide unit for the EX stage of the pipelined MIPS core.
// A 32-iteration shift-add multiplier and restoring divider produce the HI/LO
// register values read by mfhi/mflo. The hazard unit stalls mfhi/mflo and new
// mult/div instructions while `busy` is high.
//
// Ports:
//   CLK       in   1   core clock, rising-edge
//   RST       in   1   synchronous active-high reset
//   start     in   1   single-cycle request, sampled only in IDLE
//   isMult    in   1   mult/multu (wins if isDiv is also high)
//   isDiv     in   1   div/divu
//   isSigned  in   1   signed (mult/div) vs unsigned (multu/divu)
//   rs        in  32   multiplicand / dividend
//   rt        in  32   multiplier / divisor
//   mthi      in   1   write mt_data to HI (only with MD_MTHILO_EN)
//   mtlo      in   1   write mt_data to LO (only with MD_MTHILO_EN)
//   mt_data   in  32   data for mthi/mtlo (only with MD_MTHILO_EN)
//   busy      out  1   high from the cycle after an accepted start through FIXUP
//   done      out  1   one-cycle pulse when HI/LO first show the new result
//   hi_o      out 32   HI register
//   lo_o      out 32   LO register
//
// Optional feature macro: MD_MTHILO_EN adds the mthi/mtlo write path.
//
// Timing: start accepted at edge E0 -> 32 CALC cycles + 1 FIXUP cycle with
// busy high; HI/LO, done=1 and busy=0 appear in the following cycle. A start
// in the done cycle is accepted (state is already IDLE).
// -----------------------------------------------------------------------------
module md_iter_unit (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic        isMult,
  input  logic        isDiv,
  input  logic        isSigned,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
`ifdef MD_MTHILO_EN
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] mt_data,
`endif
  output logic        busy,
  output logic        done,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } state_t;

  state_t state;
  logic [5:0] iterCnt;

  // Operation context captured at accept time
  logic              opMult;
  logic              opSigned;
  logic              signQ;
  logic              signR;
  logic              divZero;
  logic [DATA_W-1:0] rsOrig;

  // addend: multiplicand magnitude (mult) or divisor magnitude (div).
  // acc:    mult -> {partial product high, multiplier shifting out LSB-first}
  //         div  -> {partial remainder, dividend shifting out / quotient in}
  logic [DATA_W-1:0]   addend;
  logic [2*DATA_W-1:0] acc;

  logic accept;

  // ---------------------------------------------------------------------------
  // Arithmetic helpers
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] neg32(input logic [31:0] v);
    logic signed [31:0] sv;
    sv = $signed(v);
    return 32'(-sv);
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    logic signed [63:0] sv;
    sv = $signed(v);
    return 64'(-sv);
  endfunction

  // Two's-complement absolute value when signed and negative; raw otherwise.
  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic sgn);
    logic signed [31:0] sv;
    sv = $signed(v);
    if (sgn && (sv < 0)) return neg32(v);
    return v;
  endfunction

  assign accept = (state == IDLE) && start && (isMult || isDiv);

  // ---------------------------------------------------------------------------
  // One iteration of each engine
  // ---------------------------------------------------------------------------
  logic [DATA_W:0]     mulSum;
  logic [2*DATA_W-1:0] mulNext;
  logic [DATA_W:0]     divShift;
  logic [DATA_W:0]     divTrial;
  logic [2*DATA_W-1:0] divNext;

  always_comb begin
    // Shift-add: add multiplicand into the high half when the current
    // multiplier LSB is set, then shift the whole accumulator right by one.
    mulSum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, addend} : 33'd0);
    mulNext = {mulSum, acc[31:1]};

    // Restoring divide: 33-bit shifted remainder keeps the bit that would
    // otherwise be lost when the divisor is >= 2^31. The remainder is always
    // below the divisor, so it fits back into 32 bits either way.
    divShift = {acc[63:32], acc[31]};
    divTrial = divShift - {1'b0, addend};
    if (divTrial[DATA_W])
      divNext = {divShift[31:0], acc[30:0], 1'b0};
    else
      divNext = {divTrial[31:0], acc[30:0], 1'b1};
  end

  // ---------------------------------------------------------------------------
  // FIXUP result selection
  // ---------------------------------------------------------------------------
  logic [2*DATA_W-1:0] mulRes;
  logic [DATA_W-1:0]   divHi;
  logic [DATA_W-1:0]   divLo;
  logic [DATA_W-1:0]   fixHi;
  logic [DATA_W-1:0]   fixLo;

  always_comb begin
    mulRes = (opSigned && signQ) ? neg64(acc) : acc;

    if (divZero) begin
      // Divide by zero bypasses the sign fixup entirely.
      divHi = rsOrig;
      divLo = 32'hFFFF_FFFF;
    end else begin
      // 0x80000000 / -1 falls out naturally: magnitude quotient 0x80000000,
      // negated back to 0x80000000, remainder 0.
      divHi = (opSigned && signR) ? neg32(acc[63:32]) : acc[63:32];
      divLo = (opSigned && signQ) ? neg32(acc[31:0])  : acc[31:0];
    end

    if (opMult) begin
      fixHi = mulRes[63:32];
      fixLo = mulRes[31:0];
    end else begin
      fixHi = divHi;
      fixLo = divLo;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers (no reset: only meaningful after an accepted start)
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (accept) begin
      opMult   <= isMult;
      opSigned <= isSigned;
      signQ    <= rs[31] ^ rt[31];
      signR    <= rs[31];
      divZero  <= (rt == 32'd0);
      rsOrig   <= rs;
      if (isMult) begin
        addend <= magnitude(rs, isSigned);
        acc    <= {32'd0, magnitude(rt, isSigned)};
      end else begin
        addend <= magnitude(rt, isSigned);
        acc    <= {32'd0, magnitude(rs, isSigned)};
      end
    end else if (state == CALC) begin
      acc <= opMult ? mulNext : divNext;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM and architectural HI/LO
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      iterCnt <= 6'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi_o    <= 32'd0;
      lo_o    <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= CALC;
            iterCnt <= 6'd0;
            busy    <= 1'b1;
          end
`ifdef MD_MTHILO_EN
          else begin
            if (mthi) hi_o <= mt_data;
            if (mtlo) lo_o <= mt_data;
          end
`endif
        end
        CALC: begin
          iterCnt <= iterCnt + 6'd1;
          if (iterCnt == 6'd31) state <= FIXUP;
        end
        FIXUP: begin
          hi_o  <= fixHi;
          lo_o  <= fixLo;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/md_iter_unit.md
# md_iter_unit

Iterative multiply/divide unit for the pipelined MIPS core. Sits in EX beside the main ALU. Consumes the forwarded rs/rt operands and the mult/div/signed decodes of the instruction in ID/EX, and produces the HI/LO register values read by mfhi/mflo through the Mult_Mux path. It replaces single-cycle 64-bit arithmetic with a 32-iteration shift-add / restoring-divide engine, and exposes `busy` so the hazard logic can stall mfhi/mflo and further mult/div instructions.

## Interface
Parameters:
- none; datapath width is fixed at 32.

Ports:
- `CLK`  in  1  core clock; all state changes on rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request; sampled only in IDLE.
- `isMult`  in  1  operation is mult/multu (qualifies `start`).
- `isDiv`  in  1  operation is div/divu (qualifies `start`); `isMult` and `isDiv` both high is illegal, and mult wins.
- `isSigned`  in  1  signed (mult/div) vs unsigned (multu/divu).
- `rs`  in  32  multiplicand / dividend.
- `rt`  in  32  multiplier / divisor.
- `busy`  out  1  high from the cycle after an accepted start through the FIXUP cycle.
- `done`  out  1  one-cycle pulse in the cycle HI/LO first show the new result.
- `hi_o`  out  32  HI register.
- `lo_o`  out  32  LO register.
- `mthi`, `mtlo`, `mt_data`  in  1/1/32  present only with `MD_MTHILO_EN` (see Configuration).

## Operation
- States: IDLE, CALC, FIXUP.
- **IDLE:** `start & (isMult|isDiv)` → CALC.
  - Latch the operation and the signedness.
  - Latch the operands as magnitudes: two's-complement absolute value when signed and the MSB is 1; raw otherwise.
  - Latch sign_q = sign(rs) ^ sign(rt) and sign_r = sign(rs).
  - Clear the 6-bit iteration counter.
  - `start` with neither op flag is ignored.
- **CALC:** exactly 32 iterations, then → FIXUP.
  - Mult: 64-bit accumulator, shift-add, LSB-first on the multiplier.
  - Div: restoring division. 33-bit partial remainder; each iteration shift left, trial-subtract the divisor, set the quotient bit if the result is non-negative.
- **FIXUP:** one cycle, then → IDLE. HI/LO are written at the end of this cycle.
  - Mult: {hi,lo} = product, negated (64-bit) if signed and sign_q.
  - Div: lo = quotient, negated if signed and sign_q; hi = remainder, negated if signed and sign_r.
  - Divide by zero (rt==0, either signedness): hi = original rs, lo = 0xFFFFFFFF. Sign fixup is bypassed.
  - Signed 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0, with no trap.
- **Outside FIXUP:** HI/LO hold their previous values throughout CALC, so stale values stay readable.
- **`start` while busy:** ignored. No queueing, and the operation in flight is unaffected. The hazard unit must hold the instruction.
- **Reset:**
  - State = IDLE; `busy` = 0; `done` = 0; `hi_o` = `lo_o` = 0; counter = 0.
  - Reset mid-operation aborts it with no HI/LO update and no `done` pulse.

## Timing
- Accepted start at edge E0:
  - `busy` = 1 from the cycle after E0 through the FIXUP cycle, i.e. 33 cycles (32 CALC + 1 FIXUP).
  - New HI/LO visible, `done` = 1 and `busy` = 0 in the cycle after FIXUP, i.e. 34 cycles after E0.
- Back-to-back: a new `start` is accepted in the same cycle `done` is high. No dead cycle.
- Outputs are registered; there is no combinational path from inputs to outputs.
- The stall contract: mfhi/mflo or mult/div in ID while `busy` = 1 must stall.

## Configuration
- `MD_MTHILO_EN` defined:
  - Adds `mthi`, `mtlo` and `mt_data`.
  - In IDLE with no accepted start, `mthi` writes `mt_data` to HI and `mtlo` writes it to LO on the next edge. Both may be asserted together.
  - An accepted `start` in the same cycle takes priority, and the mt write is dropped.
  - While busy, mt writes are ignored.
- `MD_MTHILO_EN` undefined: the ports are absent, and HI/LO are written only by FIXUP and reset.

## Test plan
- Unsigned multu 0xFFFFFFFF × 0xFFFFFFFF → after 34 cycles hi=0xFFFFFFFE, lo=0x00000001, `done` pulses once, and `busy` is high for exactly 33 cycles.
- Signed mult −3 (0xFFFFFFFD) × 7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then mult 0x80000000 × 0x80000000 → hi=0x40000000, lo=0.
- Signed div −7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Unsigned divu 0xFFFFFFF9 / 2 → lo=0x7FFFFFFC, hi=1. Signed 0x80000000 / −1 → lo=0x80000000, hi=0.
- Divide by zero: divu 100 / 0 → hi=0x00000064, lo=0xFFFFFFFF. div −5 / 0 → hi=0xFFFFFFFB, lo=0xFFFFFFFF.
- Second `start` asserted at cycle 10 of an operation → ignored, and the first result is correct. A `start` in the `done` cycle is accepted, and its result arrives 34 cycles later.
- `RST` at cycle 20 of a mult → next cycle `busy`=0 and hi/lo=0, with no `done` pulse. With `MD_MTHILO_EN`: mthi 0x1234 in IDLE → hi=0x1234; mthi during busy → no change.
